display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 126 ++++++++++++
 tb/tb_display_scan.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with anode blanking and buzzer drive.
// Ports: clk, reset (async high), digit0..3[6:0], alarmBeep -> seg[6:0], an[3:0] (low), buzzer. Option: BEEP_TONE_EN.
module display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int TONE_DIV    = 12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] digit0,
    input  logic [6:0] digit1,
    input  logic [6:0] digit2,
    input  logic [6:0] digit3,
    input  logic       alarmBeep,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       buzzer
);

    localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

    // Out-of-range parameters stop elaboration rather than wrap silently.
    if (REFRESH_DIV < BLANK_CYC + 1 || REFRESH_DIV > 65535) begin : gBadRefresh
        $error("display_scan: REFRESH_DIV out of range");
    end
    if (BLANK_CYC < 0) begin : gBadBlank
        $error("display_scan: BLANK_CYC out of range");
    end
    if (TONE_DIV < 1 || TONE_DIV > 65535) begin : gBadTone
        $error("display_scan: TONE_DIV out of range");
    end

    logic [15:0] cnt;
    logic [15:0] cntNext;
    logic [1:0]  idx;
    logic [1:0]  idxNext;
    logic        cntWrap;
    logic        blankNext;
    logic        primed;
    logic [6:0]  digitNext;
    logic [3:0]  anNext;

    always_comb begin
        cntWrap = (cnt == CNT_LAST);
        cntNext = cntWrap ? 16'd0 : cnt + 16'd1;
        idxNext = cntWrap ? idx + 2'd1 : idx;
    end

    // Blanking is judged on the next count so an lines up with cnt/idx.
    if (BLANK_CYC == 0) begin : gNoBlank
        assign blankNext = 1'b0;
    end else begin : gBlank
        localparam logic [15:0] BLANK_W = 16'(BLANK_CYC);
        assign blankNext = (cntNext < BLANK_W);
    end

    always_comb begin
        digitNext = digit0;
        case (idxNext)
            2'd0: digitNext = digit0;
            2'd1: digitNext = digit1;
            2'd2: digitNext = digit2;
            2'd3: digitNext = digit3;
            default: digitNext = digit0;
        endcase
    end

    always_comb begin
        anNext = 4'b1111;
        if (!blankNext) begin
            anNext[idxNext] = 1'b0;
        end
    end

    // primed lets the first edge after reset load digit0 into slot 0,
    // which otherwise only gets loaded on a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 16'd0;
            idx    <= 2'd0;
            seg    <= 7'b0000000;
            an     <= 4'b1111;
            primed <= 1'b0;
        end else begin
            cnt    <= cntNext;
            idx    <= idxNext;
            an     <= anNext;
            primed <= 1'b1;
            if (cntWrap || !primed) begin
                seg <= digitNext;
            end
        end
    end

`ifdef BEEP_TONE_EN
    localparam logic [15:0] TONE_LAST = 16'(TONE_DIV - 1);

    logic [15:0] toneCnt;

    // buzzer is the tone flop itself; held low while no alarm so every
    // new request starts from phase 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toneCnt <= 16'd0;
            buzzer  <= 1'b0;
        end else if (!alarmBeep) begin
            toneCnt <= 16'd0;
            buzzer  <= 1'b0;
        end else if (toneCnt == TONE_LAST) begin
            toneCnt <= 16'd0;
            buzzer  <= ~buzzer;
        end else begin
            toneCnt <= toneCnt + 16'd1;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buzzer <= 1'b0;
        end else begin
            buzzer <= alarmBeep;
        end
    end
`endif

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan (REFRESH_DIV=8, BLANK_CYC=2, TONE_DIV=4),
// plus a BLANK_CYC=0 instance sharing the same stimulus.
module tb_display_scan;

    logic       clk;
    logic       reset;
    logic [6:0] digit0, digit1, digit2, digit3;
    logic       alarmBeep;
    logic [6:0] seg, seg0;
    logic [3:0] an, an0;
    logic       buzzer, buzzer0;

    int checks = 0;
    int errors = 0;
    int k = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl[8];

    display_scan #(.REFRESH_DIV(8), .BLANK_CYC(2), .TONE_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .alarmBeep(alarmBeep), .seg(seg), .an(an), .buzzer(buzzer)
    );

    display_scan #(.REFRESH_DIV(8), .BLANK_CYC(0), .TONE_DIV(4)) dut0 (
        .clk(clk), .reset(reset),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .alarmBeep(alarmBeep), .seg(seg0), .an(an0), .buzzer(buzzer0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %h want %h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    logic bz[14];
    int   slot;
    int   cnt;
    vec_t v;

    initial begin
        tbl[0] = '{4'b1111, 7'h3F};
        tbl[1] = '{4'b1110, 7'h3F};
        tbl[2] = '{4'b1111, 7'h06};
        tbl[3] = '{4'b1101, 7'h06};
        tbl[4] = '{4'b1111, 7'h5B};
        tbl[5] = '{4'b1011, 7'h5B};
        tbl[6] = '{4'b1111, 7'h4F};
        tbl[7] = '{4'b0111, 7'h4F};

        reset = 1'b1;
        alarmBeep = 1'b0;
        digit0 = 7'h3F;
        digit1 = 7'h06;
        digit2 = 7'h5B;
        digit3 = 7'h4F;

        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_buz", 32'(buzzer), 32'h0);
        chk("rst_an0", 32'(an0), 32'hF);

        @(negedge clk);
        reset = 1'b0;

        // Two full scan periods.
        for (int i = 1; i <= 64; i++) begin
            tick();
            cnt  = k % 8;
            slot = (k / 8) % 4;
            v = tbl[slot * 2 + ((cnt >= 2) ? 1 : 0)];
            chk("scan_an", 32'(an), 32'(v.an));
            chk("scan_seg", 32'(seg), 32'(v.seg));
            chk("nb_an", 32'(an0), 32'(tbl[slot * 2 + 1].an));
            chk("nb_seg", 32'(seg0), 32'(v.seg));
        end

        // Digit change mid-slot 2 (cnt=4).
        while (k < 84) tick();
        digit2 = 7'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_seg", 32'(seg), 32'h5B);
            chk("hold_an", 32'(an), 32'hB);
        end
        tick();
        chk("next_seg", 32'(seg), 32'h4F);
        while (k < 112) tick();
        chk("new_seg", 32'(seg), 32'h66);
        chk("new_blank", 32'(an), 32'hF);
        tick();
        tick();
        chk("new_seg2", 32'(seg), 32'h66);
        chk("new_an2", 32'(an), 32'hB);

        // Asynchronous reset at cnt=5, idx=2.
        while (k < 117) tick();
        chk("pre_an", 32'(an), 32'hB);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h0);
        chk("arst_buz", 32'(buzzer), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rel_seg", 32'(seg), 32'h3F);
        chk("rel_an", 32'(an), 32'hF);
        chk("rel_an0", 32'(an0), 32'hE);
        tick();
        chk("rel_an2", 32'(an), 32'hE);
        chk("rel_seg2", 32'(seg), 32'h3F);

`ifdef BEEP_TONE_EN
        bz = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 14; i++) begin
            chk("tone", 32'(buzzer), 32'(bz[i]));
            alarmBeep = (i < 12);
            tick();
        end
`else
        bz = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            chk("beep", 32'(buzzer), 32'(bz[i]));
            alarmBeep = (i < 3);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
